// File: rtl/period_meter_pkg.sv
// period_meter_pkg
//   Shared configuration for the RPM front end: default datapath width,
//   default filter/measurement parameters and the measurement FSM states.
//   No ports; imported by period_meter and period_meter_stripe_debounce.

package period_meter_pkg;

    // Width of the period / interval counter used by the whole RPM chain.
    localparam int RPM_WIDTH     = 32'd32;

    // Default number of stable synchronised samples before a level is accepted.
    localparam int PM_DEBOUNCE   = 32'd16;

    // Default shortest interval treated as a real stripe; shorter ones are glitches.
    localparam int PM_MIN_PERIOD = 32'd64;

    // Default cycles without an accepted edge before the shaft counts as stalled.
    localparam int PM_TIMEOUT    = 32'd16777216;

    // Measurement FSM states.
    typedef enum logic [0:0] {
        PM_IDLE    = 1'b0,
        PM_MEASURE = 1'b1
    } pm_state_e;

endpackage

// File: rtl/period_meter_stripe_debounce.sv
// period_meter_stripe_debounce
//   Two-flop synchroniser followed by a stable-count filter for the optical
//   stripe sensor. The filtered level follows the synchronised level only after
//   DEBOUNCE consecutive samples that differ from the current filtered level,
//   so every accepted transition has the same fixed latency.
// Ports
//   clk        in   system clock
//   rst_n      in   async active-low reset
//   sensor_in  in   raw asynchronous sensor level
//   level      out  filtered sensor level (registered)
//   rise       out  1-cycle pulse in the cycle level goes 0->1 (registered)

module period_meter_stripe_debounce
    import period_meter_pkg::*;
#(
    parameter int DEBOUNCE = PM_DEBOUNCE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor_in,
    output logic level,
    output logic rise
);

    localparam int               CNT_W    = (DEBOUNCE > 32'd1) ? $clog2(DEBOUNCE) : 32'd1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    logic [1:0]       sync_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             rise_r;

    // Two-flop synchroniser for the asynchronous sensor input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], sensor_in};
        end
    end

    // Stable-count filter: count consecutive samples that disagree with the
    // filtered level; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= '0;
            level_r <= 1'b0;
            rise_r  <= 1'b0;
        end else begin
            rise_r <= 1'b0;
            if (sync_r[1] != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    cnt_r   <= '0;
                    level_r <= sync_r[1];
                    rise_r  <= sync_r[1];
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign level = level_r;
    assign rise  = rise_r;

endmodule

// File: rtl/period_meter.sv
// period_meter
//   Front end of the RPM counter. Debounces the stripe sensor, measures clk
//   cycles between accepted rising edges, optionally averages 2**AVG_LOG2
//   intervals and publishes the result with a toggle handshake.
// Ports
//   clk            in   system clock
//   rst_n          in   async active-low reset
//   enable         in   0 holds the meter idle; outputs keep their values
//   sensor_in      in   raw asynchronous stripe sensor
//   period         out  last published period in clk cycles (all ones = stall)
//   period_change  out  flips once per published value
//   stalled        out  1 after reset or timeout until the next real publish
//   stripe_pulse   out  1-cycle pulse per debounced rising edge

module period_meter
    import period_meter_pkg::*;
#(
    parameter int PERIOD_W   = RPM_WIDTH,
    parameter int DEBOUNCE   = PM_DEBOUNCE,
    parameter int MIN_PERIOD = PM_MIN_PERIOD,
    parameter int TIMEOUT    = PM_TIMEOUT,
    parameter int AVG_LOG2   = 32'd0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                sensor_in,
    output logic [PERIOD_W-1:0] period,
    output logic                period_change,
    output logic                stalled,
    output logic                stripe_pulse
);

    localparam int                  ACC_W     = PERIOD_W + AVG_LOG2;
    localparam int                  N_W       = AVG_LOG2 + 32'd1;
    localparam logic [PERIOD_W-1:0] ONE_C     = PERIOD_W'(32'd1);
    localparam logic [PERIOD_W-1:0] MIN_C     = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] TIMEOUT_C = PERIOD_W'(TIMEOUT);
    localparam logic [N_W-1:0]      N_ONE_C   = N_W'(32'd1);
    localparam logic [N_W-1:0]      N_FULL_C  = N_W'(32'd1 << AVG_LOG2);

    logic                level_s;
    logic                rise_s;
    logic                event_s;

    pm_state_e           state_r;
    pm_state_e           state_s;
    logic [PERIOD_W-1:0] cnt_r;
    logic                restart_s;
    logic [ACC_W-1:0]    acc_r;
    logic [ACC_W-1:0]    acc_s;
    logic [ACC_W-1:0]    acc_sum_s;
    logic [N_W-1:0]      n_r;
    logic [N_W-1:0]      n_s;
    logic [N_W-1:0]      n_inc_s;
    logic [PERIOD_W-1:0] period_r;
    logic [PERIOD_W-1:0] period_s;
    logic                toggle_r;
    logic                toggle_s;
    logic                stalled_r;
    logic                stalled_s;

    period_meter_stripe_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .sensor_in (sensor_in),
        .level     (level_s),
        .rise      (rise_s)
    );

    // The rise pulse is only meaningful while the filtered level is high.
    assign event_s = rise_s & level_s;

    // Interval counter: restarts on every edge the FSM does not discard,
    // otherwise counts up and parks at TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (restart_s) begin
            cnt_r <= ONE_C;
        end else if (cnt_r != TIMEOUT_C) begin
            cnt_r <= cnt_r + ONE_C;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // FSM and publish registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= PM_IDLE;
            acc_r     <= '0;
            n_r       <= '0;
            period_r  <= '0;
            toggle_r  <= 1'b0;
            stalled_r <= 1'b1;
        end else begin
            state_r   <= state_s;
            acc_r     <= acc_s;
            n_r       <= n_s;
            period_r  <= period_s;
            toggle_r  <= toggle_s;
            stalled_r <= stalled_s;
        end
    end

    // Next-state and publish decision. An edge in the same cycle as the
    // timeout wins because the edge branch is tested first.
    always_comb begin
        state_s   = state_r;
        acc_s     = acc_r;
        n_s       = n_r;
        period_s  = period_r;
        toggle_s  = toggle_r;
        stalled_s = stalled_r;
        restart_s = event_s;
        acc_sum_s = acc_r + ACC_W'(cnt_r);
        n_inc_s   = n_r + N_ONE_C;

        if (!enable) begin
            state_s = PM_IDLE;
            acc_s   = '0;
            n_s     = '0;
        end else begin
            case (state_r)
                PM_IDLE: begin
                    if (event_s) begin
                        state_s = PM_MEASURE;
                        acc_s   = '0;
                        n_s     = '0;
                    end else begin
                        state_s = PM_IDLE;
                    end
                end
                PM_MEASURE: begin
                    if (event_s) begin
                        if (cnt_r >= MIN_C) begin
                            if (n_inc_s == N_FULL_C) begin
                                // Truncating mean; the upper bits are zero
                                // because each interval is below TIMEOUT.
                                period_s  = PERIOD_W'(acc_sum_s >> AVG_LOG2);
                                toggle_s  = ~toggle_r;
                                stalled_s = 1'b0;
                                acc_s     = '0;
                                n_s       = '0;
                            end else begin
                                acc_s = acc_sum_s;
                                n_s   = n_inc_s;
                            end
                        end else begin
                            // Too soon after the last real edge: treat as a
                            // glitch and keep measuring from that edge.
                            restart_s = 1'b0;
                        end
                    end else if (cnt_r == TIMEOUT_C) begin
                        period_s  = '1;
                        toggle_s  = ~toggle_r;
                        stalled_s = 1'b1;
                        state_s   = PM_IDLE;
                        acc_s     = '0;
                        n_s       = '0;
                    end else begin
                        state_s = PM_MEASURE;
                    end
                end
                default: begin
                    state_s = PM_IDLE;
                    acc_s   = '0;
                    n_s     = '0;
                end
            endcase
        end
    end

    assign period        = period_r;
    assign period_change = toggle_r;
    assign stalled       = stalled_r;
    assign stripe_pulse  = rise_s;

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter
//   Scoreboard bench for period_meter. Two instances share the stimulus:
//   one publishing every interval, one averaging four. The stimulus process
//   keeps an interval-level model of the spec (edge times and gaps), pushes
//   expected publishes per instance, and a negedge monitor pops and compares
//   on every period_change toggle, including the toggle time relative to the
//   stripe pulse of the edge that caused it.

module tb_period_meter;

    localparam int TO   = 10000;
    localparam int MINP = 100;
    localparam int H    = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        sensor_in = 1'b0;
    logic [31:0] period0, period2;
    logic        chg0, chg2, st0, st2, sp0, sp2;

    always #5 clk = ~clk;

    period_meter #(.PERIOD_W(32), .DEBOUNCE(4), .MIN_PERIOD(MINP), .TIMEOUT(TO), .AVG_LOG2(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sensor_in(sensor_in),
        .period(period0), .period_change(chg0), .stalled(st0), .stripe_pulse(sp0));

    period_meter #(.PERIOD_W(32), .DEBOUNCE(4), .MIN_PERIOD(MINP), .TIMEOUT(TO), .AVG_LOG2(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sensor_in(sensor_in),
        .period(period2), .period_change(chg2), .stalled(st2), .stripe_pulse(sp2));

    typedef struct {
        logic [31:0] period;
        logic        stalled;
        int          ref_k;
        int          delay;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   pt0[$];
    int   pt1[$];

    int   checks = 0;
    int   errors = 0;
    int   now = 0;
    int   edge_k = 0;
    int   rst_req = 0, rst_ack = 0;
    int   end_req = 0, end_ack = 0;
    int   mcyc = 0;
    logic prev_tog[2];

    // Model state, one set per instance (index 1 averages 2**2 intervals).
    int     avg_l[2];
    bit     m_meas[2];
    int     m_last[2];
    int     m_lastk[2];
    longint m_acc[2];
    int     m_n[2];

    // ---------------- checking ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, mcyc);
        end
    endtask

    task automatic mon_one(input int d, input logic tog, input logic [31:0] per,
                           input logic st, input logic pul);
        exp_t e;
        int   sz;
        int   pt_t;
        if (pul) begin
            if (d == 0) pt0.push_back(mcyc); else pt1.push_back(mcyc);
        end
        if (tog !== prev_tog[d]) begin
            prev_tog[d] = tog;
            sz = (d == 0) ? q0.size() : q1.size();
            if (sz == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_toggle dut%0d at cycle %0d period=%0d, required no toggle", d, mcyc, per);
            end else begin
                if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
                chk($sformatf("period_dut%0d", d), per, e.period);
                chk($sformatf("stalled_dut%0d", d), st, e.stalled);
                if (d == 0) pt_t = (e.ref_k < pt0.size()) ? pt0[e.ref_k] : -1000000;
                else        pt_t = (e.ref_k < pt1.size()) ? pt1[e.ref_k] : -1000000;
                chk($sformatf("toggle_time_dut%0d", d), mcyc, pt_t + e.delay);
            end
        end
    endtask

    // Monitor: sample outputs on the falling edge, compare toggles against the queues.
    always @(negedge clk) begin
        mcyc++;
        if (rst_req != rst_ack) begin
            rst_ack = rst_req;
            chk("rst_period0", period0, 0);
            chk("rst_change0", chg0, 0);
            chk("rst_stalled0", st0, 1);
            chk("rst_pulse0", sp0, 0);
            chk("rst_period2", period2, 0);
            chk("rst_change2", chg2, 0);
            chk("rst_stalled2", st2, 1);
            chk("rst_pulse2", sp2, 0);
        end
        if (!rst_n) begin
            prev_tog[0] = chg0;
            prev_tog[1] = chg2;
        end else begin
            mon_one(0, chg0, period0, st0, sp0);
            mon_one(1, chg2, period2, st2, sp2);
        end
        if (end_req != end_ack) begin
            end_ack = end_req;
            chk("pending_dut0", q0.size(), 0);
            chk("pending_dut2", q1.size(), 0);
            chk("pulse_count_dut0", pt0.size(), edge_k);
            chk("pulse_count_dut2", pt1.size(), edge_k);
        end
    end

    // ---------------- reference model ----------------
    task automatic push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // A stall is declared if no accepted edge arrives within TO cycles of the last one.
    task automatic model_timeout_check(input int t);
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (m_meas[d] && (t - m_last[d] > TO)) begin
                e.period  = 32'hFFFF_FFFF;
                e.stalled = 1'b1;
                e.ref_k   = m_lastk[d];
                e.delay   = TO + 1;
                push(d, e);
                m_meas[d] = 1'b0;
            end
        end
    endtask

    task automatic model_edge(input int t);
        exp_t e;
        int   k;
        k = edge_k;
        edge_k++;
        for (int d = 0; d < 2; d++) begin
            if (!enable) begin
                m_meas[d] = 1'b0;
            end else if (!m_meas[d]) begin
                m_meas[d]  = 1'b1;
                m_last[d]  = t;
                m_lastk[d] = k;
                m_acc[d]   = 0;
                m_n[d]     = 0;
            end else if (t - m_last[d] >= MINP) begin
                m_acc[d]   += t - m_last[d];
                m_n[d]     += 1;
                m_last[d]  = t;
                m_lastk[d] = k;
                if (m_n[d] == (1 << avg_l[d])) begin
                    e.period  = 32'(m_acc[d] / (1 << avg_l[d]));
                    e.stalled = 1'b0;
                    e.ref_k   = k;
                    e.delay   = 1;
                    push(d, e);
                    m_acc[d] = 0;
                    m_n[d]   = 0;
                end
            end
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
        now += n;
    endtask

    // Rising edge sp cycles after the previous one (which left us H cycles past it),
    // optionally with a 2-cycle glitch and/or a 100-cycle enable drop in the gap.
    task automatic stripe(input int sp, input bit glitch, input bit dis);
        int rem;
        rem = sp - H;
        if (!dis) model_timeout_check(now + rem);
        if (glitch) begin
            tick(20);
            sensor_in = 1'b1;
            tick(2);
            sensor_in = 1'b0;
            rem -= 22;
        end
        if (dis) begin
            tick(90);
            enable = 1'b0;
            m_meas[0] = 1'b0;
            m_meas[1] = 1'b0;
            tick(100);
            enable = 1'b1;
            rem -= 190;
        end
        tick(rem);
        sensor_in = 1'b1;
        model_edge(now);
        tick(H);
        sensor_in = 1'b0;
    endtask

    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        m_meas[0] = 1'b0;
        m_meas[1] = 1'b0;
        tick(hold);
        rst_req++;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        rst_req++;
        tick(2);
    endtask

    initial begin
        int sp;
        int r;
        bit g;
        bit ds;
        avg_l[0] = 0;
        avg_l[1] = 2;
        for (int d = 0; d < 2; d++) begin
            m_meas[d] = 1'b0; m_last[d] = 0; m_lastk[d] = 0; m_acc[d] = 0; m_n[d] = 0;
            prev_tog[d] = 1'b0;
        end

        do_reset(5);
        tick(9000);                                  // idle after reset: no toggles
        repeat (5) stripe(1000, 1'b0, 1'b0);         // steady 1000
        stripe(1000, 1'b1, 1'b0);                    // glitch in gap
        stripe(50, 1'b0, 1'b0);                      // extra edge, too short
        stripe(950, 1'b0, 1'b0);
        stripe(1000, 1'b0, 1'b0);
        stripe(12000, 1'b0, 1'b0);                   // stall, then silent edge
        stripe(1000, 1'b0, 1'b0);
        stripe(MINP, 1'b0, 1'b0);                    // exactly the minimum: accepted
        stripe(MINP - 1, 1'b0, 1'b0);                // one short: ignored
        stripe(1000 - (MINP - 1), 1'b0, 1'b0);
        stripe(TO, 1'b0, 1'b0);                      // edge on the timeout cycle wins
        stripe(TO + 1, 1'b0, 1'b0);                  // one later: stall first
        stripe(1000, 1'b0, 1'b0);                    // averaged group 1000,1002,998,1005
        stripe(1002, 1'b0, 1'b0);
        stripe(998, 1'b0, 1'b0);
        stripe(1005, 1'b0, 1'b0);
        tick(500 - H);
        do_reset(3);                                 // reset mid-measurement
        repeat (4) stripe(700, 1'b0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            r = $urandom_range(0, 7);
            if (r == 0) sp = $urandom_range(95, 105);
            else        sp = $urandom_range(100, 1200);
            g  = ($urandom_range(0, 3) == 0) && (sp >= 80);
            ds = ($urandom_range(0, 9) == 0) && (sp >= 400);
            stripe(sp, g, ds);
        end

        tick(50);
        end_req++;
        tick(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
